// File: rtl/shf_transpose.sv
// shf_transpose: GLB word mover with a bypass copy mode and a NUM x NUM element transpose mode
module shf_transpose #(
  parameter int DATA_WIDTH     = 8,
  parameter int SRAM_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 16,
  parameter int SHIFTISA_WIDTH = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      CCUSHF_CfgVld,
  output logic                      SHFCCU_CfgRdy,
  input  logic [SHIFTISA_WIDTH-1:0] CCUSHF_CfgInfo,
  output logic                      SHFCCU_Fnh,
  output logic [ADDR_WIDTH-1:0]     SHFGLB_InRdAddr,
  output logic                      SHFGLB_InRdAddrVld,
  input  logic                      GLBSHF_InRdAddrRdy,
  input  logic [SRAM_WIDTH-1:0]     GLBSHF_InRdDat,
  input  logic                      GLBSHF_InRdDatVld,
  output logic                      SHFGLB_InRdDatRdy,
  output logic [ADDR_WIDTH-1:0]     SHFGLB_OutWrAddr,
  output logic [SRAM_WIDTH-1:0]     SHFGLB_OutWrDat,
  output logic                      SHFGLB_OutWrDatVld,
  input  logic                      GLBSHF_OutWrDatRdy
);
  localparam int NUM = SRAM_WIDTH / DATA_WIDTH;
  localparam int RW  = $clog2(NUM);
  localparam int IW  = $clog2(NUM + 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(NUM - 1);
  localparam logic [IW-1:0]         ISS_FULL = IW'(NUM);
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_NUM    = ADDR_WIDTH'(NUM);

  typedef enum logic [1:0] {IDLE, STREAM, FILL, DRAIN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] in_addr_q, out_addr_q, num_q, base_q, rd_cnt_q, rx_cnt_q, wr_cnt_q;
  logic [IW-1:0]         iss_q;
  logic [RW-1:0]         row_q;
  logic                  fnh_q, out_vld_q;
  logic [SRAM_WIDTH-1:0] out_dat_q, tr_row;
  logic [SRAM_WIDTH-1:0] buf_q [NUM];

  logic [ADDR_WIDTH-1:0] cfg_in, cfg_out, cfg_num;
  logic cfg_tr, cfg_xfer, abort, rd_more, rd_xfer, dat_xfer, wr_xfer;
  logic stream_done, fill_done, drain_last, drain_done;
  logic unused_cfg;

  assign {cfg_in, cfg_out, cfg_num} = CCUSHF_CfgInfo[16 +: 3*ADDR_WIDTH];
  assign cfg_tr     = CCUSHF_CfgInfo[1:0] == 2'b01;
  assign unused_cfg = ^{CCUSHF_CfgInfo[SHIFTISA_WIDTH-1:16+3*ADDR_WIDTH], CCUSHF_CfgInfo[15:2]};

  assign rd_more            = rd_cnt_q < num_q;
  assign SHFCCU_CfgRdy      = state_q == IDLE;
  assign SHFGLB_InRdAddrVld = (state_q == STREAM && rd_more) || (state_q == FILL && rd_more && iss_q < ISS_FULL);
  assign SHFGLB_InRdAddr    = SHFGLB_InRdAddrVld ? in_addr_q + rd_cnt_q : '0;
  assign SHFGLB_InRdDatRdy  = (state_q == STREAM && (!out_vld_q || GLBSHF_OutWrDatRdy)) || state_q == FILL;
  assign SHFGLB_OutWrDatVld = (state_q == STREAM && out_vld_q) || state_q == DRAIN;
  assign SHFGLB_OutWrAddr   = state_q == DRAIN ? base_q + ADDR_WIDTH'(row_q) :
                              SHFGLB_OutWrDatVld ? out_addr_q + wr_cnt_q : '0;
  assign SHFGLB_OutWrDat    = state_q == DRAIN ? tr_row : SHFGLB_OutWrDatVld ? out_dat_q : '0;

  assign cfg_xfer    = CCUSHF_CfgVld && state_q == IDLE;
  assign abort       = CCUSHF_CfgVld && state_q != IDLE;
  assign rd_xfer     = SHFGLB_InRdAddrVld && GLBSHF_InRdAddrRdy;
  assign dat_xfer    = GLBSHF_InRdDatVld && SHFGLB_InRdDatRdy;
  assign wr_xfer     = SHFGLB_OutWrDatVld && GLBSHF_OutWrDatRdy;
  assign stream_done = state_q == STREAM && wr_xfer && wr_cnt_q == num_q - A_ONE;
  assign fill_done   = state_q == FILL && dat_xfer && (row_q == ROW_LAST || rx_cnt_q == num_q - A_ONE);
  assign drain_last  = state_q == DRAIN && wr_xfer && row_q == ROW_LAST;
  assign drain_done  = drain_last && rx_cnt_q == num_q;
  assign SHFCCU_Fnh  = fnh_q || ((stream_done || drain_done) && !abort);

  // column row_q of the buffered tile, gathered into one output word
  always_comb begin
    tr_row = '0;
    for (int i = 0; i < NUM; i++) tr_row[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[i][int'(row_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  // job sequencing: config latch, read/write counters and mode state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      num_q      <= '0;
      base_q     <= '0;
      rd_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      iss_q      <= '0;
      row_q      <= '0;
      fnh_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      fnh_q <= cfg_xfer && cfg_num == '0;
      if (abort || state_q == IDLE) begin
        rd_cnt_q  <= '0;
        rx_cnt_q  <= '0;
        wr_cnt_q  <= '0;
        iss_q     <= '0;
        row_q     <= '0;
        out_vld_q <= 1'b0;
      end
      if (abort) state_q <= IDLE;
      else begin
        case (state_q)
          IDLE: if (cfg_xfer) begin
            in_addr_q  <= cfg_in;
            out_addr_q <= cfg_out;
            base_q     <= cfg_out;
            num_q      <= cfg_num;
            if (cfg_num != '0) state_q <= cfg_tr ? FILL : STREAM;
          end
          STREAM: begin
            if (rd_xfer) rd_cnt_q <= rd_cnt_q + A_ONE;
            if (wr_xfer) wr_cnt_q <= wr_cnt_q + A_ONE;
            if (dat_xfer) begin
              out_dat_q <= GLBSHF_InRdDat;
              out_vld_q <= 1'b1;
            end else if (wr_xfer) out_vld_q <= 1'b0;
            if (stream_done) state_q <= IDLE;
          end
          FILL: begin
            if (rd_xfer) begin
              rd_cnt_q <= rd_cnt_q + A_ONE;
              iss_q    <= iss_q + 1'b1;
            end
            if (dat_xfer) begin
              rx_cnt_q <= rx_cnt_q + A_ONE;
              row_q    <= row_q + 1'b1;
            end
            if (fill_done) begin
              row_q   <= '0;
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (wr_xfer) row_q <= row_q + 1'b1;
            if (drain_last) begin
              row_q   <= '0;
              iss_q   <= '0;
              base_q  <= base_q + A_NUM;
              state_q <= drain_done ? IDLE : FILL;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // tile buffer: zeroed between tiles so rows of a short last tile read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NUM; i++) buf_q[i] <= '0;
    else if (state_q == IDLE || drain_last) for (int i = 0; i < NUM; i++) buf_q[i] <= '0;
    else if (state_q == FILL && dat_xfer) buf_q[row_q] <= GLBSHF_InRdDat;
  end
endmodule

// File: tb/tb_shf_transpose.sv
// tb_shf_transpose: directed checks of bypass, transpose, backpressure, abort and reset
module tb_shf_transpose;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         CCUSHF_CfgVld, SHFCCU_CfgRdy, SHFCCU_Fnh;
  logic [127:0] CCUSHF_CfgInfo;
  logic [15:0]  SHFGLB_InRdAddr, SHFGLB_OutWrAddr;
  logic         SHFGLB_InRdAddrVld, GLBSHF_InRdAddrRdy, GLBSHF_InRdDatVld, SHFGLB_InRdDatRdy;
  logic [255:0] GLBSHF_InRdDat, SHFGLB_OutWrDat;
  logic         SHFGLB_OutWrDatVld, GLBSHF_OutWrDatRdy;

  always #5 clk = ~clk;

  shf_transpose dut (
    .clk(clk), .rst_n(rst_n),
    .CCUSHF_CfgVld(CCUSHF_CfgVld), .SHFCCU_CfgRdy(SHFCCU_CfgRdy), .CCUSHF_CfgInfo(CCUSHF_CfgInfo),
    .SHFCCU_Fnh(SHFCCU_Fnh),
    .SHFGLB_InRdAddr(SHFGLB_InRdAddr), .SHFGLB_InRdAddrVld(SHFGLB_InRdAddrVld), .GLBSHF_InRdAddrRdy(GLBSHF_InRdAddrRdy),
    .GLBSHF_InRdDat(GLBSHF_InRdDat), .GLBSHF_InRdDatVld(GLBSHF_InRdDatVld), .SHFGLB_InRdDatRdy(SHFGLB_InRdDatRdy),
    .SHFGLB_OutWrAddr(SHFGLB_OutWrAddr), .SHFGLB_OutWrDat(SHFGLB_OutWrDat),
    .SHFGLB_OutWrDatVld(SHFGLB_OutWrDatVld), .GLBSHF_OutWrDatRdy(GLBSHF_OutWrDatRdy)
  );

  int           total = 0, fails = 0;
  int           reads = 0, fnh_cnt = 0, fnh_w = 0;
  bit           bp = 1'b0, took = 1'b0, flush = 1'b0;
  logic [15:0]  q[$];
  logic [15:0]  wa[$];
  logic [255:0] wd[$];

  function automatic logic [255:0] gen(input logic [15:0] a);
    logic [255:0] w = '0;
    for (int e = 0; e < 32; e++) w[e*8 +: 8] = 8'(a + 16'(32*e));
    return w;
  endfunction

  function automatic logic [255:0] exp_tr(input logic [15:0] in, input int num, input int t, input int j);
    logic [255:0] w = '0;
    for (int i = 0; i < 32; i++) if (t*32 + i < num) w[i*8 +: 8] = 8'(in + 16'(t*32 + i) + 16'(32*j));
    return w;
  endfunction

  function automatic logic [127:0] mk_cfg(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b, input int n);
    logic [127:0] c = '0;
    c[1:0]  = m;
    c[63:16] = {a, b, 16'(n)};
    return c;
  endfunction

  task automatic chk_i(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // GLB model: read queue, random stalls, and transfer logging just before each posedge
  initial begin
    GLBSHF_InRdAddrRdy = 1'b0;
    GLBSHF_InRdDatVld  = 1'b0;
    GLBSHF_InRdDat     = '0;
    GLBSHF_OutWrDatRdy = 1'b0;
    forever begin
      @(negedge clk);
      if (flush) begin
        q.delete();
        GLBSHF_InRdDatVld = 1'b0;
        took  = 1'b0;
        flush = 1'b0;
      end
      if (took) begin
        void'(q.pop_front());
        GLBSHF_InRdDatVld = 1'b0;
        took = 1'b0;
      end
      if (!GLBSHF_InRdDatVld && q.size() > 0 && (!bp || $urandom_range(0, 1) == 1)) begin
        GLBSHF_InRdDat    = gen(q[0]);
        GLBSHF_InRdDatVld = 1'b1;
      end
      GLBSHF_InRdAddrRdy = !bp || $urandom_range(0, 2) != 0;
      GLBSHF_OutWrDatRdy = !bp || $urandom_range(0, 2) != 0;
      #1;
      if (SHFGLB_InRdAddrVld && GLBSHF_InRdAddrRdy) begin
        q.push_back(SHFGLB_InRdAddr);
        reads++;
      end
      if (GLBSHF_InRdDatVld && SHFGLB_InRdDatRdy) took = 1'b1;
      if (SHFGLB_OutWrDatVld && GLBSHF_OutWrDatRdy) begin
        wa.push_back(SHFGLB_OutWrAddr);
        wd.push_back(SHFGLB_OutWrDat);
      end
      if (SHFCCU_Fnh) begin
        fnh_cnt++;
        fnh_w = wa.size();
      end
    end
  end

  task automatic send_cfg(input logic [1:0] m, input logic [15:0] in, input logic [15:0] out, input int num);
    @(negedge clk);
    chk_i("cfg_rdy_before", int'(SHFCCU_CfgRdy), 1);
    CCUSHF_CfgInfo = mk_cfg(m, in, out, num);
    CCUSHF_CfgVld  = 1'b1;
    @(negedge clk);
    CCUSHF_CfgVld  = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] m, input logic [15:0] in, input logic [15:0] out, input int num,
                         input bit tr, input int lim);
    int r0 = reads, f0 = fnh_cnt, n = 0;
    int exp_n = tr ? ((num + 31) / 32) * 32 : num;
    wa.delete();
    wd.delete();
    send_cfg(m, in, out, num);
    chk_i("first_rd_vld", int'(SHFGLB_InRdAddrVld), 1);
    chk_i("first_rd_addr", int'(SHFGLB_InRdAddr), int'(in));
    chk_i("cfg_rdy_busy", int'(SHFCCU_CfgRdy), 0);
    while (fnh_cnt == f0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk_i("fnh_count", fnh_cnt - f0, 1);
    chk_i("wr_count", wa.size(), exp_n);
    chk_i("rd_count", reads - r0, num);
    chk_i("fnh_at_last_wr", fnh_w, exp_n);
    for (int k = 0; k < exp_n && k < wa.size(); k++) begin
      chk_i($sformatf("waddr[%0d]", k), int'(wa[k]), int'(16'(out + 16'(k))));
      chk_w($sformatf("wdat[%0d]", k), wd[k], tr ? exp_tr(in, num, k / 32, k % 32) : gen(16'(in + 16'(k))));
    end
  endtask

  initial begin
    int f0, r0, n;
    CCUSHF_CfgVld  = 1'b0;
    CCUSHF_CfgInfo = '0;
    repeat (2) @(negedge clk);
    chk_i("rst_cfg_rdy", int'(SHFCCU_CfgRdy), 1);
    chk_i("rst_fnh", int'(SHFCCU_Fnh), 0);
    chk_i("rst_rd_vld", int'(SHFGLB_InRdAddrVld), 0);
    chk_i("rst_rd_addr", int'(SHFGLB_InRdAddr), 0);
    chk_i("rst_dat_rdy", int'(SHFGLB_InRdDatRdy), 0);
    chk_i("rst_wr_vld", int'(SHFGLB_OutWrDatVld), 0);
    chk_w("rst_wr_dat", SHFGLB_OutWrDat, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(2'b00, 16'h0100, 16'h0800, 5, 1'b0, 500);
    run_job(2'b01, 16'h0000, 16'h0040, 32, 1'b1, 2000);
    run_job(2'b01, 16'h0000, 16'h0200, 40, 1'b1, 2000);

    bp = 1'b1;
    run_job(2'b11, 16'h0300, 16'h1000, 100, 1'b0, 5000);
    run_job(2'b01, 16'h0400, 16'h2000, 64, 1'b1, 5000);
    bp = 1'b0;
    flush = 1'b1;
    repeat (3) @(negedge clk);

    wa.delete();
    wd.delete();
    f0 = fnh_cnt;
    send_cfg(2'b01, 16'h0000, 16'h3000, 64);
    repeat (5) @(negedge clk);
    chk_i("in_fill_dat_rdy", int'(SHFGLB_InRdDatRdy), 1);
    CCUSHF_CfgInfo = mk_cfg(2'b00, 16'h0000, 16'h0000, 0);
    CCUSHF_CfgVld  = 1'b1;
    @(negedge clk);
    chk_i("abort_cfg_rdy", int'(SHFCCU_CfgRdy), 1);
    chk_i("abort_no_fnh", int'(SHFCCU_Fnh), 0);
    r0 = reads;
    flush = 1'b1;
    @(negedge clk);
    CCUSHF_CfgVld = 1'b0;
    chk_i("zero_num_fnh", int'(SHFCCU_Fnh), 1);
    chk_i("zero_num_rd_vld", int'(SHFGLB_InRdAddrVld), 0);
    @(negedge clk);
    chk_i("zero_num_fnh_pulse", int'(SHFCCU_Fnh), 0);
    repeat (40) @(negedge clk);
    chk_i("abort_writes", wa.size(), 0);
    chk_i("abort_reads", reads - r0, 0);
    chk_i("abort_fnh_cnt", fnh_cnt - f0, 1);

    wa.delete();
    wd.delete();
    send_cfg(2'b01, 16'h0000, 16'h0040, 32);
    n = 0;
    while (!SHFGLB_OutWrDatVld && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_i("drain_reached", int'(SHFGLB_OutWrDatVld), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_i("mid_rst_wr_vld", int'(SHFGLB_OutWrDatVld), 0);
    chk_w("mid_rst_wr_dat", SHFGLB_OutWrDat, '0);
    chk_i("mid_rst_wr_addr", int'(SHFGLB_OutWrAddr), 0);
    chk_i("mid_rst_rd_vld", int'(SHFGLB_InRdAddrVld), 0);
    chk_i("mid_rst_dat_rdy", int'(SHFGLB_InRdDatRdy), 0);
    chk_i("mid_rst_cfg_rdy", int'(SHFCCU_CfgRdy), 1);
    chk_i("mid_rst_fnh", int'(SHFCCU_Fnh), 0);
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    run_job(2'b10, 16'h0010, 16'h0030, 1, 1'b0, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
    $finish;
  end
endmodule
